// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, oversampling constants and the
// majority-vote helper. Used by both the receive and transmit paths.
package uart_pkg;

  localparam int OVS         = 16;
  localparam int DIV_DEFAULT = 326;   // 50 MHz / (9600 * 16)

  // Oversample ticks within one bit: two early samples, then the decision.
  localparam logic [3:0] TICK_S0   = 4'd7;
  localparam logic [3:0] TICK_S1   = 4'd8;
  localparam logic [3:0] TICK_DEC  = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'd15;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// Oversample prescaler: emits a one-clock tick every DIV clocks while run
// is high; the count is held at zero while run is low so every frame
// starts from a known phase.
module rx_baud_tick #(
  parameter int DIV = 326
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

  logic [15:0] cnt;

  assign tick = run && (cnt == CNT_LAST);

  // Free-running 0..DIV-1 counter, cleared whenever reception is idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (!run || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to build the 8E1 variant with a live parity_err.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a falling edge on a line previously seen high
// START    | validating the start bit; a high vote is treated as a glitch
// DATA     | shifting in 8 data bits, LSB first
// PARITY   | capturing the even-parity bit (UART_RX_PARITY_EN only)
// STOP     | stop-bit vote; publishes the byte or flags a framing error
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int TCW = $clog2(OVS);

  logic           rxd_meta;
  logic           rxd_s;
  logic           armed;
  logic [2:0]     state;
  logic [TCW-1:0] tick_cnt;
  logic [2:0]     bit_idx;
  logic [1:0]     samp;
  logic [7:0]     shreg;
  logic           tick;
  logic           vote;
  logic           at_dec;
  logic           at_last;
`ifdef UART_RX_PARITY_EN
  logic           par_bit;
`endif

  assign busy    = (state != ST_IDLE);
  assign vote    = maj3(samp[0], samp[1], rxd_s);
  assign at_dec  = tick && (tick_cnt == TICK_DEC);
  assign at_last = tick && (tick_cnt == TICK_LAST);

  rx_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .n_rst (n_rst),
    .run   (busy),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Frame sequencer, sampling and registered output strobes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      samp       <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) tick_cnt <= tick_cnt + 1'b1;
      if (tick && tick_cnt == TICK_S0) samp[0] <= rxd_s;
      if (tick && tick_cnt == TICK_S1) samp[1] <= rxd_s;

      case (state)
        ST_IDLE: begin
          // armed blocks a stuck-low line or break from retriggering.
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state    <= ST_START;
            tick_cnt <= '0;
            bit_idx  <= '0;
            armed    <= 1'b0;
          end
        end
        ST_START: begin
          if (at_dec && vote) state <= ST_IDLE;
          else if (at_last)   state <= ST_DATA;
        end
        ST_DATA: begin
          if (at_dec) shreg <= {vote, shreg[7:1]};
          if (at_last) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (at_dec)  par_bit <= vote;
          if (at_last) state   <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // Leave at mid-stop-bit to give half a bit of resync margin.
          if (at_dec) begin
            state <= ST_IDLE;
            if (vote) begin
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= (^shreg) ^ par_bit;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at DIV=4. Frames are described at
// the bit level; the expected result of each frame (data, error flags and
// the clock at which its strobe must appear) is derived from the frame
// content and queued, and a negedge monitor matches every strobe to it.
module tb_uart_rx_frame;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_TICKS = 170;
  localparam bit HAS_PAR    = 1'b1;
`else
  localparam int STOP_TICKS = 154;
  localparam bit HAS_PAR    = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;

  uart_rx_frame #(.DIV(DIV)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  // All line tasks start and end 1 time unit after a rising edge.
  task automatic line_hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the expected outcome, then drive start, data, [parity], stop.
  // The strobe is registered 3 (sync + FSM) + STOP_TICKS*DIV edges after
  // the edge preceding the start transition.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pbit);
    ev_t e;
    e.data = d;
    e.ferr = !stop_v;
    e.perr = (HAS_PAR && stop_v) ? ((^d) ^ pbit) : 1'b0;
    e.cyc  = cyc + 3 + STOP_TICKS * DIV;
    exp_q.push_back(e);
    line_hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) line_hold(d[i], BIT);
    if (HAS_PAR) line_hold(pbit, BIT);
    line_hold(stop_v, BIT);
  endtask

  // Match every output strobe against the next queued expectation.
  always @(negedge clk) begin
    if (n_rst && (rx_valid || frame_err || parity_err)) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (!e.ferr) model_data = e.data;
        check("rx_valid",   rx_valid,   !e.ferr);
        check("frame_err",  frame_err,  e.ferr);
        check("parity_err", parity_err, e.perr);
        check("latency",    cyc,        e.cyc);
        check("rx_data",    rx_data,    model_data);
        check("busy_fall",  busy,       1'b0);
      end
    end
  end

  initial begin
    int k;
    logic [7:0] d;
    logic       stop_v;
    logic       pbit;
    logic       last_bad;

    n_rst = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data",    rx_data,    8'h00);
    check("rst_rx_valid",   rx_valid,   1'b0);
    check("rst_frame_err",  frame_err,  1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_busy",       busy,       1'b0);
    n_rst = 1'b1;
    line_hold(1'b1, 100);

    // Good byte.
    send_frame(8'hA5, 1'b1, ^8'hA5);
    line_hold(1'b1, 20);
    check("a5_done", exp_q.size(), 0);

    // Start glitch of two ticks: must be rejected at the first decision.
    k = cyc;
    line_hold(1'b0, 2 * DIV);
    line_hold(1'b1, 2);
    check("glitch_busy_rise", busy, 1'b1);
    while (cyc < k + 3 + 10 * DIV + 2) line_hold(1'b1, 1);
    check("glitch_busy_fall", busy, 1'b0);
    check("glitch_no_pulse", exp_q.size(), 0);
    line_hold(1'b1, 20);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    line_hold(1'b1, 20);

    // Framing error, then a line stuck low must not start a new frame.
    send_frame(8'h5A, 1'b0, ^8'h5A);
    line_hold(1'b0, 3 * BIT);
    check("stuck_low_busy", busy, 1'b0);
    check("ferr_hold_data", rx_data, 8'h3C);
    line_hold(1'b1, 20);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h81, 1'b1, ^8'h81);
    line_hold(1'b1, 20);
    check("b2b_done", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    line_hold(1'b1, 20);
    send_frame(8'h07, 1'b1, 1'b0);
    line_hold(1'b1, 20);
`endif

    // Reset during data bit 4: partial byte discarded, outputs reset.
    d = 8'h96;
    line_hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) line_hold(d[i], BIT);
    line_hold(d[4], BIT / 2);
    n_rst = 1'b0;
    rxd   = 1'b1;
    #1;
    check("midrst_rx_data",   rx_data,   8'h00);
    check("midrst_busy",      busy,      1'b0);
    check("midrst_rx_valid",  rx_valid,  1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    model_data = 8'h00;
    line_hold(1'b1, 5);
    n_rst = 1'b1;
    line_hold(1'b1, 100);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    line_hold(1'b1, 20);

    // Randomized frames: occasional bad stop / bad parity, random gaps.
    last_bad = 1'b0;
    for (int n = 0; n < 30; n++) begin
      d      = 8'($urandom);
      stop_v = ($urandom_range(0, 6) != 0);
      pbit   = (^d) ^ ($urandom_range(0, 4) == 0);
      if (last_bad) line_hold(1'b1, 20 + $urandom_range(0, 30));
      else if ($urandom_range(0, 1) == 1) line_hold(1'b1, $urandom_range(1, 30));
      send_frame(d, stop_v, pbit);
      last_bad = !stop_v;
    end
    line_hold(1'b1, 20);

    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    check("all_frames_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
